axi_lite_master: RTL
====================

// Module: axi_lite_master
// PURPOSE
//  AXI4-Lite initiator for the ADC capture design. Converts single-beat register commands
//  (from a bring-up sequencer or test logic) into AXI4-Lite write/read transactions.
//  Drives the slave register bank that produces DATA_EN and DDR_RESET.
//  One outstanding transaction. Each command returns exactly one response beat.
// PARAMETERS
//  C_M_AXI_DATA_WIDTH  32    data width, 32 or 64
//  C_M_AXI_ADDR_WIDTH  32    address width
//  C_TIMEOUT_CYCLES    1024  wait cycles allowed per phase before timeout_err is set; min 2
// PORTS
//  m_axi_aclk     in   1    clock, single domain
//  m_axi_aresetn  in   1    asynchronous active-low reset
//  cmd_valid      in   1    command request
//  cmd_ready      out  1    command accepted when valid&ready
//  cmd_write      in   1    1=write, 0=read
//  cmd_addr       in   AW   byte address, passed through unmodified
//  cmd_wdata      in   DW   write data
//  cmd_wstrb      in   DW/8 write strobes
//  rsp_valid      out  1    response available
//  rsp_ready      in   1    response consumed when valid&ready
//  rsp_rdata      out  DW   read data; 0 for writes
//  rsp_resp       out  2    BRESP/RRESP of the transaction
//  timeout_err    out  1    sticky: some phase exceeded C_TIMEOUT_CYCLES
//  m_axi_aw*/w*/b*/ar*/r*   full AXI4-Lite master set: awaddr, awprot, awvalid, awready,
//                           wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr,
//                           arprot, arvalid, arready, rdata, rresp, rvalid, rready
// BEHAVIOUR
//  Reset values: all outputs 0. Exception: cmd_ready=1 once aresetn is deasserted and FSM is IDLE.
//  FSM states: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, RSP.
//   IDLE: cmd_ready=1. On accept, register addr/data/strb. Go to WR or RD_ADDR.
//   WR: awvalid and wvalid both asserted in the cycle after accept.
//     Each valid drops independently on its own handshake. Either order or both same cycle is legal.
//     Exit to WR_RESP only when both handshakes are done.
//   WR_RESP: bready=1. On bvalid, capture bresp, set rdata=0, go to RSP.
//   RD_ADDR: arvalid=1 until arready. Then RD_DATA.
//   RD_DATA: rready=1. On rvalid, capture rdata/rresp, go to RSP.
//   RSP: rsp_valid=1, held stable until rsp_ready. Then IDLE.
//  awprot/arprot fixed 3'b000. All AXI valids are registered outputs.
//   A valid never drops before its handshake, including on timeout.
//  Latency, zero-wait slave, accept in cycle N:
//   valid out at N+1, B/R handshake at N+2, rsp_valid at N+3.
//   Back-to-back throughput is 1 command per 4 cycles.
//  Timeout: counter clears on every state change and counts cycles spent in a wait state.
//   Reaching C_TIMEOUT_CYCLES sets timeout_err; the FSM keeps waiting (AXI compliant).
//   timeout_err clears on the next cmd accept.
//  Slave responses SLVERR and DECERR are passed through; no retry.
//  Reset mid-transaction: everything returns to reset values immediately (async).
//   No response is emitted for the aborted command.
// STRUCTURE
//  Shared package axi_lite_pkg:
//   RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
//   FSM state encoding.
//  One sub-module: axi_lite_timeout_cnt (clear, enable, terminal count -> tick).
// TESTING
//  1. Write 0x0000_0004 <- 0x1, wstrb 0xF, zero-wait slave
//     -> awvalid/wvalid at N+1, rsp_valid at N+3, rsp_resp 0, slave DDR_RESET=1.
//  2. Slave holds awready low 3 cycles, wready immediate
//     -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one B handshake.
//  3. Read 0x0000_0000 after writing 0x1
//     -> arvalid N+1, rsp_rdata 0x1, rsp_resp 0; rsp_ready low 5 cycles -> rsp held stable.
//  4. Slave returns RRESP=2'b10
//     -> rsp_resp 2'b10, cmd_ready returns after rsp handshake.
//  5. C_TIMEOUT_CYCLES=16, slave never asserts bvalid
//     -> timeout_err=1 at 16 cycles, bready stays 1; late bvalid completes; next cmd clears flag.
//  6. aresetn low while in WR_RESP
//     -> all valids 0 next edge, no rsp_valid; after release, new command completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM encoding and a state helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  // States where the master is waiting on the slave and the timeout applies.
  function automatic logic is_wait_state(state_t s);
    return (s == ST_WR) || (s == ST_WR_RESP) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle with master and slave views.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_timeout_cnt.sv
// Per-phase wait timer: down-counter reloaded on clear, ticks on the cycle it reaches
// terminal count while enabled, so the tick lands on the C_TIMEOUT_CYCLES-th waited cycle.
module axi_lite_timeout_cnt #(
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic m_axi_aclk,
  input  logic m_axi_aresetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int            CW   = $clog2(C_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(C_TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn)
      r_cnt <= LOAD;
    else if (i_clr)
      r_cnt <= LOAD;
    else if (i_en && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator turning register commands into write/read
// transactions with one response beat per command and a sticky per-phase timeout flag.
//
// state      | meaning
// IDLE       | cmd_ready=1, waiting for a command
// WR         | awvalid/wvalid up, each dropping on its own handshake
// WR_RESP    | bready=1, waiting for bvalid
// RD_ADDR    | arvalid up until arready
// RD_DATA    | rready=1, waiting for rvalid
// RSP        | rsp_valid held until rsp_ready
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            timeout_err,
  axi_lite_if.master                      m_axi
);

  state_t r_state;
  state_t w_state_nxt;

  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] r_wstrb;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]                      r_resp;
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_arvalid;
  logic                            r_timeout_err;

  logic w_cmd_acc;
  logic w_tmo_clr;
  logic w_tmo_en;
  logic w_tmo_tick;

  assign w_cmd_acc = cmd_valid && cmd_ready;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // WR leaves only once both channels have handshaken, in whichever order they arrive.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_cmd_acc) w_state_nxt = cmd_write ? ST_WR : ST_RD_ADDR;
      ST_WR:      if ((!r_awvalid || m_axi.awready) && (!r_wvalid || m_axi.wready))
                    w_state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (m_axi.bvalid)  w_state_nxt = ST_RSP;
      ST_RD_ADDR: if (m_axi.arready) w_state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (m_axi.rvalid)  w_state_nxt = ST_RSP;
      ST_RSP:     if (rsp_ready)     w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_rdata       <= '0;
      r_resp        <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_cmd_acc) begin
        r_addr        <= cmd_addr;
        r_wdata       <= cmd_wdata;
        r_wstrb       <= cmd_wstrb;
        r_awvalid     <= cmd_write;
        r_wvalid      <= cmd_write;
        r_arvalid     <= !cmd_write;
        r_timeout_err <= 1'b0;
      end else if (w_tmo_tick) begin
        r_timeout_err <= 1'b1;
      end
      if (r_awvalid && m_axi.awready) r_awvalid <= 1'b0;
      if (r_wvalid  && m_axi.wready)  r_wvalid  <= 1'b0;
      if (r_arvalid && m_axi.arready) r_arvalid <= 1'b0;
      if ((r_state == ST_WR_RESP) && m_axi.bvalid) begin
        r_rdata <= '0;
        r_resp  <= m_axi.bresp;
      end
      if ((r_state == ST_RD_DATA) && m_axi.rvalid) begin
        r_rdata <= m_axi.rdata;
        r_resp  <= m_axi.rresp;
      end
    end
  end

  // Timer restarts on every state change; the FSM keeps waiting after a timeout.
  assign w_tmo_clr = (w_state_nxt != r_state);
  assign w_tmo_en  = is_wait_state(r_state) && !w_tmo_clr;

  axi_lite_timeout_cnt #(
    .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .m_axi_aclk   (m_axi_aclk),
    .m_axi_aresetn(m_axi_aresetn),
    .i_clr        (w_tmo_clr),
    .i_en         (w_tmo_en),
    .o_tick       (w_tmo_tick)
  );

  assign cmd_ready   = (r_state == ST_IDLE) && m_axi_aresetn;
  assign rsp_valid   = (r_state == ST_RSP);
  assign rsp_rdata   = r_rdata;
  assign rsp_resp    = r_resp;
  assign timeout_err = r_timeout_err;

  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = (r_state == ST_WR_RESP);
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = (r_state == ST_RD_DATA);

endmodule
